// File: rtl/sync_fifo_fwft.sv
// -----------------------------------------------------------------------------
// sync_fifo_fwft
//   Single-clock FIFO with arbitrary depth, selectable first-word-fall-through
//   or registered read, programmable almost-full/almost-empty thresholds,
//   synchronous flush and sticky overflow/underflow error flags.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   flush         synchronous clear of contents/pointers (beats read/write)
//   clr_err       synchronous clear of overflow/underflow
//   wr_en, din    write request and data
//   full          count == DEPTH
//   almost_full   count >= AFULL_LEVEL
//   overflow      sticky: write requested while full
//   rd_en         read request
//   dout          read data (oldest word in FWFT mode, registered otherwise)
//   empty         count == 0
//   almost_empty  count <= AEMPTY_LEVEL
//   underflow     sticky: read requested while empty
//   count         occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo_fwft #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 32,
  parameter int FWFT         = 1,
  parameter int AFULL_LEVEL  = DEPTH - 2,
  parameter int AEMPTY_LEVEL = 1,
  localparam int CW          = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  clr_err,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  underflow,
  output logic [CW-1:0]         count
);

  localparam int            PW     = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST   = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AFULL_LEVEL);
  localparam logic [CW-1:0] AE_C   = CW'(AEMPTY_LEVEL);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_ovf;
  logic                  r_udf;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;
  logic w_wr_rej;
  logic w_rd_rej;

  // Status comes only from the registered count, so request inputs never
  // reach full/empty/count combinationally.
  assign w_full  = (r_count == FULL_C);
  assign w_empty = (r_count == '0);

  // Flush swallows both requests: nothing is accepted and nothing is flagged.
  assign w_wr_acc = wr_en && !w_full  && !flush;
  assign w_rd_acc = rd_en && !w_empty && !flush;
  assign w_wr_rej = wr_en &&  w_full  && !flush;
  assign w_rd_rej = rd_en &&  w_empty && !flush;

  // Storage array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      // Explicit wrap so that non-power-of-two depths work.
      if (w_wr_acc) r_wptr <= (r_wptr == LAST) ? '0 : r_wptr + PW'(1);
      if (w_rd_acc) r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + PW'(1);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Holds the most recently popped word. In registered mode it is the output;
  // in FWFT mode it keeps dout stable while the FIFO is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout <= '0;
    end else if (w_rd_acc) begin
      r_dout <= r_mem[r_rptr];
    end
  end

  // Sticky error flags: a new rejection wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_wr_rej)     r_ovf <= 1'b1;
      else if (clr_err) r_ovf <= 1'b0;
      if (w_rd_rej)     r_udf <= 1'b1;
      else if (clr_err) r_udf <= 1'b0;
    end
  end

  assign dout         = (FWFT != 0 && !w_empty) ? r_mem[r_rptr] : r_dout;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= AF_C);
  assign almost_empty = (r_count <= AE_C);
  assign overflow     = r_ovf;
  assign underflow    = r_udf;
  assign count        = r_count;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_fwft
//   Directed bench for sync_fifo_fwft. Three instances share clock, reset and
//   write data; each has its own request/flush/clear controls:
//     index 0: DEPTH=32, FWFT=1, AFULL=30, AEMPTY=1
//     index 1: DEPTH=5,  FWFT=1 (non-power-of-two wrap, full/empty corners)
//     index 2: DEPTH=4,  FWFT=0 (registered read, async reset mid-stream)
// -----------------------------------------------------------------------------
module tb_sync_fifo_fwft;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic [2:0] wr  = '0;
  logic [2:0] rd  = '0;
  logic [2:0] fl  = '0;
  logic [2:0] ce  = '0;

  int vecs = 0;
  int errs = 0;

  logic       full0, afull0, ovf0, empty0, aempty0, udf0;
  logic [7:0] dout0;
  logic [5:0] cnt0;
  logic       full1, afull1, ovf1, empty1, aempty1, udf1;
  logic [7:0] dout1;
  logic [3:0] cnt1;
  logic       full2, afull2, ovf2, empty2, aempty2, udf2;
  logic [7:0] dout2;
  logic [2:0] cnt2;

  always #5 clk = ~clk;

  sync_fifo_fwft #(.DATA_WIDTH(8), .DEPTH(32), .FWFT(1), .AFULL_LEVEL(30), .AEMPTY_LEVEL(1)) u32 (
    .clk(clk), .rst(rst), .flush(fl[0]), .clr_err(ce[0]), .wr_en(wr[0]), .din(din),
    .full(full0), .almost_full(afull0), .overflow(ovf0), .rd_en(rd[0]), .dout(dout0),
    .empty(empty0), .almost_empty(aempty0), .underflow(udf0), .count(cnt0));

  sync_fifo_fwft #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(1)) u5 (
    .clk(clk), .rst(rst), .flush(fl[1]), .clr_err(ce[1]), .wr_en(wr[1]), .din(din),
    .full(full1), .almost_full(afull1), .overflow(ovf1), .rd_en(rd[1]), .dout(dout1),
    .empty(empty1), .almost_empty(aempty1), .underflow(udf1), .count(cnt1));

  sync_fifo_fwft #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(0)) u4 (
    .clk(clk), .rst(rst), .flush(fl[2]), .clr_err(ce[2]), .wr_en(wr[2]), .din(din),
    .full(full2), .almost_full(afull2), .overflow(ovf2), .rd_en(rd[2]), .dout(dout2),
    .empty(empty2), .almost_empty(aempty2), .underflow(udf2), .count(cnt2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given controls on instance k; outputs are
  // examined 1 time unit after the edge, controls return to idle.
  task automatic cyc(input int k, input logic we, input logic re, input logic f,
                     input logic c, input logic [7:0] d);
    wr[k] = we; rd[k] = re; fl[k] = f; ce[k] = c; din = d;
    @(posedge clk); #1;
    wr = '0; rd = '0; fl = '0; ce = '0;
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_count",  32'(cnt0),    32'd0);
    chk("rst_empty",  32'(empty0),  32'd1);
    chk("rst_full",   32'(full0),   32'd0);
    chk("rst_afull",  32'(afull0),  32'd0);
    chk("rst_aempty", 32'(aempty0), 32'd1);
    chk("rst_ovf",    32'(ovf0),    32'd0);
    chk("rst_udf",    32'(udf0),    32'd0);
    chk("rst_dout",   32'(dout0),   32'd0);
    chk("rst_dout_r", 32'(dout2),   32'd0);

    // FWFT basic: write 01..05, read back in order
    cyc(0, 1, 0, 0, 0, 8'h01);
    chk("fwft_empty_fall", 32'(empty0), 32'd0);
    chk("fwft_first_word", 32'(dout0),  32'h01);
    chk("fwft_count1",     32'(cnt0),   32'd1);
    for (int i = 2; i <= 5; i++) cyc(0, 1, 0, 0, 0, 8'(i));
    chk("fwft_count5",  32'(cnt0),    32'd5);
    chk("fwft_aempty5", 32'(aempty0), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("fwft_rd%0d", i), 32'(dout0), 32'(i));
      cyc(0, 0, 1, 0, 0, 8'h00);
    end
    chk("fwft_empty_end", 32'(empty0), 32'd1);
    chk("fwft_count_end", 32'(cnt0),   32'd0);

    // Thresholds on the 32-deep instance, then flush with a write pending
    cyc(0, 1, 0, 0, 0, 8'h00);
    chk("thr_aempty_c1", 32'(aempty0), 32'd1);
    cyc(0, 1, 0, 0, 0, 8'h01);
    chk("thr_aempty_c2", 32'(aempty0), 32'd0);
    for (int i = 2; i < 29; i++) cyc(0, 1, 0, 0, 0, 8'(i));
    chk("thr_count29", 32'(cnt0),  32'd29);
    chk("thr_afull29", 32'(afull0), 32'd0);
    cyc(0, 1, 0, 0, 0, 8'd29);
    chk("thr_afull30", 32'(afull0), 32'd1);
    chk("thr_full30",  32'(full0),  32'd0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 0, 8'h00);
    chk("thr_count20",  32'(cnt0), 32'd20);
    chk("thr_dout20",   32'(dout0), 32'd10);
    cyc(0, 1, 0, 1, 0, 8'h77);
    chk("flush_count",  32'(cnt0),   32'd0);
    chk("flush_empty",  32'(empty0), 32'd1);
    chk("flush_ovf",    32'(ovf0),   32'd0);

    // DEPTH=5: offset pointers by 2 so every round wraps mid-stream
    cyc(1, 1, 0, 0, 0, 8'h00);
    cyc(1, 1, 0, 0, 0, 8'h00);
    cyc(1, 0, 1, 0, 0, 8'h00);
    cyc(1, 0, 1, 0, 0, 8'h00);
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 4; j++) cyc(1, 1, 0, 0, 0, 8'(8'hA0 + r * 5 + j));
      chk($sformatf("wrap_r%0d_full4", r), 32'(full1), 32'd0);
      cyc(1, 1, 0, 0, 0, 8'(8'hA0 + r * 5 + 4));
      chk($sformatf("wrap_r%0d_full5", r), 32'(full1), 32'd1);
      chk($sformatf("wrap_r%0d_cnt5", r),  32'(cnt1),  32'd5);
      for (int j = 0; j < 5; j++) begin
        chk($sformatf("wrap_r%0d_rd%0d", r, j), 32'(dout1), 32'(8'hA0 + r * 5 + j));
        cyc(1, 0, 1, 0, 0, 8'h00);
      end
      chk($sformatf("wrap_r%0d_empty", r), 32'(empty1), 32'd1);
    end

    // Overflow: full + write + read drops the write
    for (int j = 0; j < 5; j++) cyc(1, 1, 0, 0, 0, 8'(8'h10 + j));
    chk("ovf_full", 32'(full1), 32'd1);
    cyc(1, 1, 1, 0, 0, 8'hEE);
    chk("ovf_count4", 32'(cnt1), 32'd4);
    chk("ovf_flag",   32'(ovf1), 32'd1);
    for (int j = 1; j < 5; j++) begin
      chk($sformatf("ovf_rd%0d", j), 32'(dout1), 32'(8'h10 + j));
      cyc(1, 0, 1, 0, 0, 8'h00);
    end
    chk("ovf_empty_no_ee", 32'(empty1), 32'd1);
    cyc(1, 0, 0, 0, 1, 8'h00);
    chk("ovf_clr", 32'(ovf1), 32'd0);

    // Underflow: empty read, then empty + write + read
    cyc(1, 0, 1, 0, 0, 8'h00);
    chk("udf_flag",   32'(udf1), 32'd1);
    chk("udf_count0", 32'(cnt1), 32'd0);
    cyc(1, 1, 1, 0, 0, 8'h3C);
    chk("udf_count1", 32'(cnt1),  32'd1);
    chk("udf_dout",   32'(dout1), 32'h3C);
    cyc(1, 0, 1, 0, 0, 8'h00);
    chk("udf_empty",  32'(empty1), 32'd1);
    cyc(1, 0, 1, 0, 1, 8'h00);
    chk("udf_set_beats_clr", 32'(udf1), 32'd1);
    cyc(1, 0, 0, 0, 1, 8'h00);
    chk("udf_clr", 32'(udf1), 32'd0);

    // Registered read mode
    cyc(2, 1, 0, 0, 0, 8'h11);
    cyc(2, 1, 0, 0, 0, 8'h22);
    chk("std_dout_before", 32'(dout2), 32'd0);
    chk("std_count2",      32'(cnt2),  32'd2);
    cyc(2, 0, 1, 0, 0, 8'h00);
    chk("std_dout_rd",  32'(dout2), 32'h11);
    chk("std_count1",   32'(cnt2),  32'd1);
    cyc(2, 0, 0, 0, 0, 8'h00);
    chk("std_dout_hold", 32'(dout2), 32'h11);
    cyc(2, 1, 0, 0, 0, 8'h33);
    chk("std_count2b", 32'(cnt2), 32'd2);

    // Asynchronous reset pulse between edges
    #2 rst = 1'b1;
    #1;
    chk("arst_count", 32'(cnt2),   32'd0);
    chk("arst_empty", 32'(empty2), 32'd1);
    chk("arst_dout",  32'(dout2),  32'd0);
    chk("arst_full",  32'(full2),  32'd0);
    #1 rst = 1'b0;
    cyc(2, 1, 0, 0, 0, 8'h44);
    cyc(2, 0, 1, 0, 0, 8'h00);
    chk("arst_ptr_restart", 32'(dout2), 32'h44);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/sync_fifo_fwft.md
# sync_fifo_fwft

Parametrised single-clock FIFO, the next generation of the design's byte FIFO for the serial/GPS and display-command paths. It adds arbitrary (non-power-of-two) depth, selectable standard or first-word-fall-through read mode, programmable almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags. Illegal accesses are guarded: writes when full and reads when empty are dropped and flagged, never corrupting state.

## Interface
- DATA_WIDTH, 8, word width in bits
- DEPTH, 32, number of words; any integer >= 2
- FWFT, 1, 1 = first-word-fall-through, 0 = standard registered read
- AFULL_LEVEL, DEPTH-2, almost_full asserts when count >= this
- AEMPTY_LEVEL, 1, almost_empty asserts when count <= this
- CW (local), $clog2(DEPTH)+1, width of count

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- flush  in  1  synchronous clear of contents and pointers
- clr_err  in  1  synchronous clear of overflow/underflow
- wr_en  in  1  write request
- din  in  DATA_WIDTH  write data
- full  out  1  count == DEPTH
- almost_full  out  1  count >= AFULL_LEVEL
- overflow  out  1  sticky: write requested while full
- rd_en  in  1  read request
- dout  out  DATA_WIDTH  read data
- empty  out  1  count == 0
- almost_empty  out  1  count <= AEMPTY_LEVEL
- underflow  out  1  sticky: read requested while empty
- count  out  CW  current occupancy, 0..DEPTH

## Operation
- Write accepted iff wr_en && !full; read accepted iff rd_en && !empty. Acceptance decided on registered flags of the current cycle.
- Write pointer and read pointer wrap from DEPTH-1 to 0 (explicit compare, not power-of-two rollover).
- count: +1 on accepted write only, -1 on accepted read only, unchanged on both or neither. Never exceeds DEPTH, never below 0.
- Full + wr_en + rd_en: read accepted, write dropped, overflow set, count -> DEPTH-1.
- Empty + wr_en + rd_en: write accepted, read dropped, underflow set, count -> 1.
- flush: pointers and count to 0 next edge; overrides any same-cycle read/write (neither accepted, no flag set); dout unchanged in FWFT=0, undefined-but-stable in FWFT=1 while empty.
- Error flags: set on any rejected request, cleared only by clr_err or rst; set beats clr_err in the same cycle.
- FWFT=0: dout registered, updated only on accepted read, holds otherwise.
- FWFT=1: whenever empty is low, dout presents the oldest word; accepted read pops it and dout shows the next word (or empty rises) the following cycle.
- All flags derived from registered count/state; no combinational path from wr_en/rd_en to full/empty/count.

## Timing
- Reset (async assert, sync deassert by top level): count 0, empty 1, full 0, almost_full 0 (AFULL_LEVEL>0), almost_empty 1, overflow 0, underflow 0, dout 0, pointers 0.
- Write in cycle N: count, empty, full, almost flags reflect it in cycle N+1.
- FWFT=1: word written into empty FIFO in cycle N appears on dout with empty low in cycle N+1.
- FWFT=0: read accepted in cycle M gives data on dout in cycle M+1.
- Sustained simultaneous read/write at 1 word/cycle with count constant, in any fill state except full/empty edge cases above.
- rst asserted mid-operation: immediate return to reset values regardless of clk; stored RAM contents need not be cleared.

## Test plan
- Reset then write 0x01..0x05 (FWFT=1): empty falls cycle after first write, dout=0x01; 5 reads return 0x01..0x05, empty=1, count=0.
- DEPTH=5 (non-power-of-two): 3 cycles of write-5/read-5 with pattern A0+i: order preserved across wrap, full asserts exactly at count=5.
- Fill to full, drive wr_en+rd_en with din=0xEE: count=4 (DEPTH=5), overflow=1, 0xEE never read; clr_err -> overflow=0.
- Empty FIFO, rd_en alone then wr_en+rd_en din=0x3C: underflow=1, count=1, next read returns 0x3C.
- Thresholds DEPTH=32, AFULL=30, AEMPTY=1: almost_empty drops at count=2, almost_full rises at count=30; flush at count=20 with wr_en high -> count=0, empty=1 next cycle.
- FWFT=0: write 0x11,0x22; rd_en one cycle -> dout=0x11 one cycle later and held; async rst pulse mid-stream -> all outputs at reset values before next edge.
